// File: rtl/sonar_pkg.sv
// Shared definitions for the multi-channel sonar ranger.
// Holds the FSM state encoding, the register-window offsets, the CTRL/STAT
// bit positions and a small priority-search helper used for channel selection.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam logic [7:0] CTRL_OFS  = 8'd0;
  localparam logic [7:0] STAT_OFS  = 8'd1;
  localparam logic [7:0] MASK_OFS  = 8'd2;
  localparam logic [7:0] RANGE_OFS = 8'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_CH_LSB  = 4;

  // Lowest set bit of mask at index >= from. Result is {found, index}.
  // Scanning downwards lets the lowest qualifying bit overwrite the others.
  function automatic logic [3:0] first_set_from(input logic [7:0] mask,
                                                input logic [3:0] from);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sonar_prescaler.sv
// Free-running microsecond prescaler.
// Counts 0..CLK_DIV-1 and pulses tick for the one cycle where the count
// sits at CLK_DIV-1.
// Ports: clk (clock), rst_n (synchronous active-low reset), tick (1-cycle pulse).
module sonar_prescaler
  import sonar_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [15:0] count_r;
  logic [15:0] count_nxt_s;
  logic        tick_r;

  // Next prescaler count with wrap at CLK_DIV-1.
  always_comb begin
    count_nxt_s = (count_r == 16'(CLK_DIV - 1)) ? 16'd0 : count_r + 16'd1;
  end

  // Count register; tick is registered so it is high exactly while count_r == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 16'd0;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tick_r  <= (count_nxt_s == 16'(CLK_DIV - 1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/sonar_array.sv
// Multi-channel ultrasonic ranger on the 8-bit memory-mapped bus.
// Fires the enabled transducers one at a time in ascending order, times each
// echo in microsecond ticks and converts the width into inches.
// Ports: clk, rst_n (sync active-low); bus din/address/w_en/r_en -> dout
// (registered, one cycle after r_en); echo[CHANNELS] async inputs;
// trig[CHANNELS] one-hot trigger outputs; irq = done & irq_en.
module sonar_array
  import sonar_pkg::*;
#(
  parameter int         CHANNELS     = 4,
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         CLK_DIV      = 16,
  parameter int         TRIG_US      = 10,
  parameter int         TIMEOUT_US   = 35000,
  parameter int         PERIOD_US    = 60000,
  parameter int         RANGE_MUL    = 219,
  parameter int         RANGE_SHIFT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          din,
  input  logic [7:0]          address,
  input  logic                w_en,
  input  logic                r_en,
  output logic [7:0]          dout,
  input  logic [CHANNELS-1:0] echo,
  output logic [CHANNELS-1:0] trig,
  output logic                irq
);

  localparam logic [7:0] CH_MASK = 8'((16'd1 << CHANNELS) - 16'd1);

  logic                tick_s;
  logic [CHANNELS-1:0] echo_meta_r, echo_sync_r;
  logic [7:0]          echo8_s;
  logic                echo_bit_s;
  state_t              state_r, state_nxt_s;
  logic [15:0]         cnt_r, cnt_nxt_s;
  logic [2:0]          ch_r, ch_nxt_s;
  logic [2:0]          ctrl_r, ctrl_w_s, ctrl_nxt_s;
  logic                done_r, done_nxt_s, timeout_r, timeout_nxt_s;
  logic [7:0]          mask_r;
  logic [7:0]          range_r [CHANNELS];
  logic [CHANNELS-1:0] trig_r, trig_nxt_s;
  logic [7:0]          dout_r, rd_s, ofs_s;
  logic                irq_r, busy_s;
  logic                wr_ctrl_s, wr_stat_s, wr_mask_s;
  logic                clr_start_s, set_done_s, set_timeout_s, range_we_s;
  logic [7:0]          range_wdata_s, range_calc_s;
  logic [23:0]         prod_s, scaled_s;
  logic [3:0]          first_s, next_s;

  sonar_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_s)
  );

  assign ofs_s     = address - BASE_ADDRESS;
  assign wr_ctrl_s = w_en && (ofs_s == CTRL_OFS);
  assign wr_stat_s = w_en && (ofs_s == STAT_OFS);
  assign wr_mask_s = w_en && (ofs_s == MASK_OFS);
  assign busy_s    = (state_r != IDLE);

  // Channel search, echo of the active channel and the saturating range conversion.
  always_comb begin
    first_s      = first_set_from(mask_r, 4'd0);
    next_s       = first_set_from(mask_r, {1'b0, ch_r} + 4'd1);
    echo8_s      = 8'd0;
    echo8_s[CHANNELS-1:0] = echo_sync_r;
    echo_bit_s   = echo8_s[ch_r];
    prod_s       = 24'(cnt_r) * 24'(RANGE_MUL);
    scaled_s     = prod_s >> RANGE_SHIFT;
    range_calc_s = (scaled_s > 24'd255) ? 8'hFF : scaled_s[7:0];
  end

  // Sweep FSM: next state, counter, channel and register side effects; acts on ticks only.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    ch_nxt_s      = ch_r;
    clr_start_s   = 1'b0;
    set_done_s    = 1'b0;
    set_timeout_s = 1'b0;
    range_we_s    = 1'b0;
    range_wdata_s = 8'd0;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (ctrl_r[CTRL_START]) begin
            if (first_s[3]) begin
              ch_nxt_s    = first_s[2:0];
              cnt_nxt_s   = 16'd0;
              state_nxt_s = TRIG;
            end else begin
              set_done_s  = 1'b1;
              clr_start_s = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        TRIG: begin
          if (cnt_r == 16'(TRIG_US - 1)) begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = WAIT_ECHO;
          end else begin
            cnt_nxt_s = cnt_r + 16'd1;
          end
        end
        WAIT_ECHO: begin
          if (echo_bit_s) begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = MEASURE;
          end else if (cnt_r == 16'(TIMEOUT_US)) begin
            // The counter keeps running so the holdoff still ends on the period boundary.
            range_we_s    = 1'b1;
            range_wdata_s = 8'hFF;
            set_timeout_s = 1'b1;
            cnt_nxt_s     = cnt_r + 16'd1;
            state_nxt_s   = HOLDOFF;
          end else begin
            cnt_nxt_s = cnt_r + 16'd1;
          end
        end
        MEASURE: begin
          cnt_nxt_s = cnt_r + 16'd1;
          if (!echo_bit_s || (cnt_r == 16'(TIMEOUT_US))) begin
            range_we_s    = 1'b1;
            range_wdata_s = range_calc_s;
            set_timeout_s = (cnt_r == 16'(TIMEOUT_US));
            state_nxt_s   = HOLDOFF;
          end else begin
            state_nxt_s = MEASURE;
          end
        end
        HOLDOFF: begin
          if (cnt_r == 16'(PERIOD_US - 1)) begin
            cnt_nxt_s = 16'd0;
            if (next_s[3]) begin
              ch_nxt_s    = next_s[2:0];
              state_nxt_s = TRIG;
            end else if (ctrl_r[CTRL_CONT] && ctrl_r[CTRL_START] && first_s[3]) begin
              // End of a continuous sweep: flag it and start over.
              set_done_s  = 1'b1;
              ch_nxt_s    = first_s[2:0];
              state_nxt_s = TRIG;
            end else begin
              set_done_s  = 1'b1;
              clr_start_s = 1'b1;
              state_nxt_s = IDLE;
            end
          end else begin
            cnt_nxt_s = cnt_r + 16'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Control/status next values: hardware start-clear beats a CTRL write,
  // hardware set beats a W1C.
  always_comb begin
    ctrl_w_s      = wr_ctrl_s ? din[2:0] : ctrl_r;
    ctrl_nxt_s    = {ctrl_w_s[2:1], ctrl_w_s[0] & ~clr_start_s};
    done_nxt_s    = set_done_s | (done_r & ~(wr_stat_s & din[STAT_DONE]));
    timeout_nxt_s = set_timeout_s | (timeout_r & ~(wr_stat_s & din[STAT_TIMEOUT]));
    for (int i = 0; i < CHANNELS; i++) begin
      trig_nxt_s[i] = (state_nxt_s == TRIG) && (ch_nxt_s == 3'(i));
    end
  end

  // Read data mux; unmapped offsets return zero.
  always_comb begin
    rd_s = 8'd0;
    case (ofs_s)
      CTRL_OFS: rd_s = {5'd0, ctrl_r};
      STAT_OFS: begin
        rd_s[STAT_BUSY]                 = busy_s;
        rd_s[STAT_DONE]                 = done_r;
        rd_s[STAT_TIMEOUT]              = timeout_r;
        rd_s[STAT_CH_LSB+2:STAT_CH_LSB] = ch_r;
      end
      MASK_OFS: rd_s = mask_r;
      default:  rd_s = 8'd0;
    endcase
    for (int i = 0; i < CHANNELS; i++) begin
      if (ofs_s == RANGE_OFS + 8'(i)) begin
        rd_s = range_r[i];
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, register file, echo synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_meta_r <= '0;
      echo_sync_r <= '0;
      cnt_r       <= 16'd0;
      ch_r        <= 3'd0;
      ctrl_r      <= 3'd0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      mask_r      <= CH_MASK;
      trig_r      <= '0;
      irq_r       <= 1'b0;
      dout_r      <= 8'd0;
      for (int i = 0; i < CHANNELS; i++) begin
        range_r[i] <= 8'd0;
      end
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      cnt_r       <= cnt_nxt_s;
      ch_r        <= ch_nxt_s;
      ctrl_r      <= ctrl_nxt_s;
      done_r      <= done_nxt_s;
      timeout_r   <= timeout_nxt_s;
      mask_r      <= wr_mask_s ? (din & CH_MASK) : mask_r;
      trig_r      <= trig_nxt_s;
      irq_r       <= done_nxt_s & ctrl_nxt_s[CTRL_IRQ_EN];
      dout_r      <= r_en ? rd_s : dout_r;
      for (int i = 0; i < CHANNELS; i++) begin
        if (range_we_s && (ch_r == 3'(i))) begin
          range_r[i] <= range_wdata_s;
        end
      end
    end
  end

  assign dout = dout_r;
  assign trig = trig_r;
  assign irq  = irq_r;

endmodule

// File: tb/tb_sonar_array.sv
// Self-checking bench for sonar_array, run with shortened timing parameters.
module tb_sonar_array;

  localparam int         CH   = 4;
  localparam logic [7:0] BASE = 8'h10;
  localparam int         CD   = 4;
  localparam int         TRT  = 3;
  localparam int         TMO  = 200;
  localparam int         PER  = 300;
  localparam int         MUL  = 219;
  localparam int         SHF  = 6;

  localparam logic [7:0] A_CTRL = BASE + 8'd0;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_MASK = BASE + 8'd2;
  localparam logic [7:0] A_RNG  = BASE + 8'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    din = 8'd0, address = 8'd0;
  logic          w_en = 1'b0, r_en = 1'b0;
  logic [7:0]    dout;
  logic [CH-1:0] echo = '0;
  logic [CH-1:0] trig;
  logic          irq;

  sonar_array #(
    .CHANNELS(CH), .BASE_ADDRESS(BASE), .CLK_DIV(CD), .TRIG_US(TRT),
    .TIMEOUT_US(TMO), .PERIOD_US(PER), .RANGE_MUL(MUL), .RANGE_SHIFT(SHF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .address(address), .w_en(w_en),
    .r_en(r_en), .dout(dout), .echo(echo), .trig(trig), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic mon1 = 1'b0;
  logic trig1_seen = 1'b0;
  always @(posedge clk) if (mon1 && trig[1]) trig1_seen <= 1'b1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[14];

  function automatic vec_t mk(logic wr, logic [7:0] a, logic [7:0] d, logic [7:0] e, string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.name = n;
    return v;
  endfunction

  // Range the specification defines for a final counter value.
  function automatic logic [7:0] exp_range(int c);
    longint p;
    p = (longint'(c) * MUL) >>> SHF;
    return (p > 255) ? 8'hFF : 8'(p);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(logic [7:0] a, logic [7:0] d);
    @(negedge clk);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  // Read through the scoreboard: expectation queued at issue, checked when dout lands.
  task automatic bus_read(logic [7:0] a, logic [7:0] e, string name);
    sb_t s;
    @(negedge clk);
    address = a; r_en = 1'b1;
    s.name = name; s.exp = e;
    sb_q.push_back(s);
    @(negedge clk);
    r_en = 1'b0;
    s = sb_q.pop_front();
    check(s.name, dout, s.exp);
  endtask

  task automatic read_raw(logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    v = dout;
  endtask

  task automatic wait_idle(int budget, string name);
    logic [7:0] v;
    v = 8'hFF;
    for (int n = 0; n < budget && v[0]; n++) read_raw(A_STAT, v);
    check(name, v[0], 1'b0);
  endtask

  task automatic wait_trig(int ch, int budget, string name);
    for (int n = 0; n < budget && !trig[ch]; n++) @(negedge clk);
    check(name, trig[ch], 1'b1);
  endtask

  task automatic wait_trig_fall(int ch);
    for (int n = 0; n < 1000 && trig[ch]; n++) @(negedge clk);
  endtask

  task automatic wait_irq(int budget, string name);
    for (int n = 0; n < budget && !irq; n++) @(negedge clk);
    check(name, irq, 1'b1);
  endtask

  // Echo pulse of exactly d ticks on channel ch, started shortly after its trigger.
  task automatic sweep(int ch, int d, string name);
    wait_trig(ch, 3000, name);
    wait_trig_fall(ch);
    repeat (5 * CD) @(negedge clk);
    echo[ch] = 1'b1;
    repeat (d * CD) @(negedge clk);
    echo[ch] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c0, d;
    vecs[0]  = mk(1'b0, BASE + 8'd7, 8'h00, 8'h00, "unmapped_hi");
    vecs[1]  = mk(1'b0, BASE - 8'd1, 8'h00, 8'h00, "unmapped_lo");
    vecs[2]  = mk(1'b1, A_RNG, 8'hAA, 8'h00, "");
    vecs[3]  = mk(1'b0, A_RNG, 8'h00, 8'h00, "range_ro");
    vecs[4]  = mk(1'b1, A_MASK, 8'h0A, 8'h00, "");
    vecs[5]  = mk(1'b0, A_MASK, 8'h00, 8'h0A, "mask_rw");
    vecs[6]  = mk(1'b1, A_MASK, 8'hFF, 8'h00, "");
    vecs[7]  = mk(1'b0, A_MASK, 8'h00, 8'h0F, "mask_width");
    vecs[8]  = mk(1'b1, A_CTRL, 8'h06, 8'h00, "");
    vecs[9]  = mk(1'b0, A_CTRL, 8'h00, 8'h06, "ctrl_rw");
    vecs[10] = mk(1'b1, A_STAT, 8'hF9, 8'h00, "");
    vecs[11] = mk(1'b0, A_STAT, 8'h00, 8'h00, "stat_ro");
    vecs[12] = mk(1'b1, A_CTRL, 8'hF8, 8'h00, "");
    vecs[13] = mk(1'b0, A_CTRL, 8'h00, 8'h00, "ctrl_upper");

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 4'h0);
    check("rst_dout", dout, 8'h00);
    check("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    bus_read(A_STAT, 8'h00, "rst_stat");
    bus_read(A_MASK, 8'h0F, "rst_mask");
    bus_read(A_CTRL, 8'h00, "rst_ctrl");

    // Single channel measurement with trigger width check
    bus_write(A_MASK, 8'h01);
    bus_write(A_CTRL, 8'h01);
    wait_trig(0, 200, "t1_trig_rise");
    w = 0;
    while (trig[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("t1_trig_width", w, TRT * CD);
    repeat (20 * CD) @(negedge clk);
    echo[0] = 1'b1;
    repeat (20 * CD) @(negedge clk);
    echo[0] = 1'b0;
    wait_idle(2000, "t1_idle");
    // Counter is cleared on the tick that sees the echo, so a d-tick echo ends at d-1.
    bus_read(A_RNG, exp_range(19), "t1_range0");
    bus_read(A_STAT, 8'h02, "t1_stat");
    bus_read(A_CTRL, 8'h00, "t1_start_cleared");

    // No echo: timeout in WAIT_ECHO
    bus_write(A_STAT, 8'h06);
    bus_write(A_MASK, 8'h02);
    bus_write(A_CTRL, 8'h01);
    wait_trig(1, 200, "t2_trig1");
    wait_idle(3000, "t2_idle");
    bus_read(A_RNG + 8'd1, 8'hFF, "t2_range1");
    bus_read(A_STAT, 8'h16, "t2_stat");
    bus_write(A_STAT, 8'h06);
    bus_read(A_STAT, 8'h10, "t2_w1c");

    // Masked channel skipped, period spacing, MEASURE timeout with saturation
    bus_write(A_MASK, 8'h05);
    mon1 = 1'b1;
    bus_write(A_CTRL, 8'h01);
    wait_trig(0, 200, "t3_trig0");
    wait_trig_fall(0);
    repeat (5 * CD) @(negedge clk);
    echo[0] = 1'b1;
    c0 = cyc;
    repeat (50 * CD) @(negedge clk);
    echo[0] = 1'b0;
    wait_trig(2, 3000, "t3_trig2");
    d = cyc - c0;
    vectors++;
    if (d < PER * CD + 3 || d > PER * CD + CD + 2) begin
      miscompares++;
      $display("FAIL t3_period: got %0d clocks, expected %0d..%0d", d, PER * CD + 3, PER * CD + CD + 2);
    end
    wait_trig_fall(2);
    repeat (5 * CD) @(negedge clk);
    echo[2] = 1'b1;
    wait_idle(3000, "t3_idle");
    echo[2] = 1'b0;
    mon1 = 1'b0;
    bus_read(A_RNG, exp_range(49), "t3_range0");
    bus_read(A_RNG + 8'd2, exp_range(TMO), "t3_range2");
    bus_read(A_STAT, 8'h26, "t3_stat");
    check("t3_trig1_never", trig1_seen, 1'b0);

    // Continuous mode with interrupt, then stop mid-MEASURE
    bus_write(A_STAT, 8'h06);
    bus_write(A_MASK, 8'h01);
    bus_write(A_CTRL, 8'h07);
    sweep(0, 10, "t4_sweep1");
    wait_irq(3000, "t4_irq1");
    bus_read(A_STAT, 8'h03, "t4_stat_busy_done");
    bus_write(A_STAT, 8'h02);
    check("t4_irq_clear", irq, 1'b0);
    sweep(0, 10, "t4_sweep2");
    wait_irq(3000, "t4_irq2");
    bus_write(A_STAT, 8'h02);
    wait_trig(0, 3000, "t4_sweep3");
    wait_trig_fall(0);
    repeat (5 * CD) @(negedge clk);
    echo[0] = 1'b1;
    repeat (5 * CD) @(negedge clk);
    bus_write(A_CTRL, 8'h06);
    repeat (10 * CD) @(negedge clk);
    echo[0] = 1'b0;
    wait_idle(3000, "t4_idle");
    check("t4_irq_final", irq, 1'b1);
    bus_read(A_CTRL, 8'h06, "t4_ctrl");
    bus_read(A_STAT, 8'h02, "t4_stat");

    // Reset in the middle of MEASURE
    bus_write(A_STAT, 8'h06);
    bus_write(A_CTRL, 8'h01);
    wait_trig(0, 200, "t5_trig0");
    wait_trig_fall(0);
    repeat (5 * CD) @(negedge clk);
    echo[0] = 1'b1;
    repeat (10 * CD) @(negedge clk);
    bus_read(A_MASK, 8'h01, "t5_pre_mask");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_trig", trig, 4'h0);
    check("t5_dout", dout, 8'h00);
    check("t5_irq", irq, 1'b0);
    echo[0] = 1'b0;
    bus_read(A_STAT, 8'h00, "t5_stat");
    bus_read(A_MASK, 8'h0F, "t5_mask");
    for (int i = 0; i < CH; i++) bus_read(A_RNG + 8'(i), 8'h00, $sformatf("t5_range%0d", i));

    // Register map table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // dout holds while r_en is low
    bus_read(A_MASK, 8'h0F, "hold_setup");
    address = A_STAT;
    repeat (3) @(negedge clk);
    check("hold_dout", dout, 8'h0F);

    // Empty mask: done immediately, start cleared
    bus_write(A_MASK, 8'h00);
    bus_write(A_CTRL, 8'h01);
    repeat (2 * CD) @(negedge clk);
    bus_read(A_STAT, 8'h02, "mask0_stat");
    bus_read(A_CTRL, 8'h00, "mask0_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
